ldst_control_unit: RTL and testbench

Hardwired control sequencer replacing hand-driven fetch/load stimulus with an autonomous state machine. It fetches an instruction, decodes the opcode presented from IR, and issues the datapath control strobes (PCout, MARin, MDRin, IRin, Gra/Grb, BAout, Yin, Cout, ADD, Zin, Zlowout, Rin, Rout) for LD, LDI, ST and HALT. It generalises the fixed T0–T7 LD sequence with:
- parametrised opcode encodings and width;
- configurable memory wait states;
- a store path;
- run/stop control, halt and illegal-opcode detection.

---
 rtl/ldst_control_unit.sv | 195 +++++++++++++++++++
 tb/tb_ldst_control_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ldst_control_unit.sv
// ldst_control_unit
//   Hardwired Moore sequencer for a simple CPU datapath. It fetches an
//   instruction (F0..F2), decodes the opcode at T3 and then drives the
//   execute steps (T4..T7) for LD, LDI and ST. HALT and any undefined
//   opcode park the machine in HALTED until clear is asserted.
//
// Ports
//   clock      in   system clock, rising-edge
//   clear      in   asynchronous active-low reset
//   run        in   1 permits starting a new instruction
//   ir_opcode  in   opcode field from IR (valid from the cycle after IRin)
//   PCout .. Zlowout  out  datapath control strobes
//   instr_done out  one-cycle pulse in the final step of an instruction
//   halted     out  1 while parked in HALTED
//   illegal    out  1 when HALTED was reached through an undefined opcode
module ldst_control_unit #(
    parameter int            OPW      = 5,
    parameter int            MEM_WAIT = 0,
    parameter logic [OPW-1:0] OP_LD   = OPW'(5'b00000),
    parameter logic [OPW-1:0] OP_LDI  = OPW'(5'b00001),
    parameter logic [OPW-1:0] OP_ST   = OPW'(5'b00010),
    parameter logic [OPW-1:0] OP_HALT = OPW'(5'b11011)
) (
    input  logic           clock,
    input  logic           clear,
    input  logic           run,
    input  logic [OPW-1:0] ir_opcode,
    output logic           PCout,
    output logic           IncPC,
    output logic           MARin,
    output logic           memRead,
    output logic           memWrite,
    output logic           ramEnable,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Gra,
    output logic           Grb,
    output logic           Rin,
    output logic           Rout,
    output logic           BAout,
    output logic           Yin,
    output logic           Cout,
    output logic           ADD,
    output logic           Zin,
    output logic           Zlowout,
    output logic           instr_done,
    output logic           halted,
    output logic           illegal
);

    localparam int WCW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LOAD = WCW'(MEM_WAIT);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_F0     = 4'd1;
    localparam logic [3:0] S_F1     = 4'd2;
    localparam logic [3:0] S_F2     = 4'd3;
    localparam logic [3:0] S_T3     = 4'd4;
    localparam logic [3:0] S_T4     = 4'd5;
    localparam logic [3:0] S_T5     = 4'd6;
    localparam logic [3:0] S_T6     = 4'd7;
    localparam logic [3:0] S_T7     = 4'd8;
    localparam logic [3:0] S_HALTED = 4'd9;

    logic [3:0]     state_q,   state_d;
    logic [WCW-1:0] wcnt_q,    wcnt_d;
    logic [OPW-1:0] op_q,      op_d;
    logic           illegal_q, illegal_d;

    function automatic logic is_ldst(input logic [OPW-1:0] op);
        return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    endfunction

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic. run is looked at only in IDLE and in the final
    // step of an instruction, so dropping it mid-instruction never aborts.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_F0;
            S_F0: begin
                state_d = S_F1;
                wcnt_d  = WAIT_LOAD;
            end
            S_F1: begin
                if (wcnt_q == '0) state_d = S_F2;
                else              wcnt_d  = wcnt_q - WCW'(1);
            end
            S_F2: state_d = S_T3;
            S_T3: begin
                // Latch the opcode so later IR changes cannot disturb T4..T7.
                op_d = ir_opcode;
                if (is_ldst(ir_opcode)) begin
                    state_d = S_T4;
                end else begin
                    state_d = S_HALTED;
                    if (ir_opcode != OP_HALT) illegal_d = 1'b1;
                end
            end
            S_T4: state_d = S_T5;
            S_T5: begin
                if (op_q == OP_LDI) begin
                    state_d = run ? S_F0 : S_IDLE;
                end else begin
                    state_d = S_T6;
                    if (op_q == OP_LD) wcnt_d = WAIT_LOAD;
                end
            end
            S_T6: begin
                if (op_q == OP_LD) begin
                    if (wcnt_q == '0) state_d = S_T7;
                    else              wcnt_d  = wcnt_q - WCW'(1);
                end else begin
                    // Store: register read is single-cycle, memory write follows.
                    state_d = S_T7;
                    wcnt_d  = WAIT_LOAD;
                end
            end
            S_T7: begin
                if ((op_q == OP_ST) && (wcnt_q != '0)) wcnt_d  = wcnt_q - WCW'(1);
                else                                   state_d = run ? S_F0 : S_IDLE;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobe decode from the current state (T3 also looks at the opcode
    // field to suppress the address-calculation strobes for HALT/illegal).
    always_comb begin
        PCout = 1'b0; IncPC = 1'b0; MARin = 1'b0; memRead = 1'b0;
        memWrite = 1'b0; ramEnable = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
        IRin = 1'b0; Gra = 1'b0; Grb = 1'b0; Rin = 1'b0; Rout = 1'b0;
        BAout = 1'b0; Yin = 1'b0; Cout = 1'b0; ADD = 1'b0; Zin = 1'b0;
        Zlowout = 1'b0; instr_done = 1'b0; halted = 1'b0;
        case (state_q)
            S_F0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            S_F1: begin memRead = 1'b1; ramEnable = 1'b1; MDRin = 1'b1; end
            S_F2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (is_ldst(ir_opcode)) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end
            end
            S_T4: begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
            S_T5: begin
                Zlowout = 1'b1;
                if (op_q == OP_LDI) begin
                    Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
                end else begin
                    MARin = 1'b1;
                end
            end
            S_T6: begin
                MDRin = 1'b1;
                if (op_q == OP_LD) begin
                    memRead = 1'b1; ramEnable = 1'b1;
                end else begin
                    Gra = 1'b1; Rout = 1'b1;
                end
            end
            S_T7: begin
                if (op_q == OP_LD) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
                end else begin
                    ramEnable  = 1'b1;
                    memWrite   = 1'b1;
                    instr_done = (wcnt_q == '0);
                end
            end
            S_HALTED: halted = 1'b1;
            default: ;
        endcase
    end

    assign illegal = illegal_q;

endmodule

// File: tb/tb_ldst_control_unit.sv
module tb_ldst_control_unit;

    localparam int W = 2;
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef logic [21:0] vec_t;
    localparam vec_t M_PCO  = vec_t'(1) << 0;
    localparam vec_t M_INC  = vec_t'(1) << 1;
    localparam vec_t M_MARI = vec_t'(1) << 2;
    localparam vec_t M_MRD  = vec_t'(1) << 3;
    localparam vec_t M_MWR  = vec_t'(1) << 4;
    localparam vec_t M_RAM  = vec_t'(1) << 5;
    localparam vec_t M_MDRI = vec_t'(1) << 6;
    localparam vec_t M_MDRO = vec_t'(1) << 7;
    localparam vec_t M_IRI  = vec_t'(1) << 8;
    localparam vec_t M_GRA  = vec_t'(1) << 9;
    localparam vec_t M_GRB  = vec_t'(1) << 10;
    localparam vec_t M_RIN  = vec_t'(1) << 11;
    localparam vec_t M_ROUT = vec_t'(1) << 12;
    localparam vec_t M_BAO  = vec_t'(1) << 13;
    localparam vec_t M_YIN  = vec_t'(1) << 14;
    localparam vec_t M_COUT = vec_t'(1) << 15;
    localparam vec_t M_ADD  = vec_t'(1) << 16;
    localparam vec_t M_ZIN  = vec_t'(1) << 17;
    localparam vec_t M_ZLO  = vec_t'(1) << 18;
    localparam vec_t M_DONE = vec_t'(1) << 19;
    localparam vec_t M_HLT  = vec_t'(1) << 20;
    localparam vec_t M_ILL  = vec_t'(1) << 21;

    logic clock = 1'b0;
    logic clear, run;
    logic [4:0] ir_opcode;
    logic PCout, IncPC, MARin, memRead, memWrite, ramEnable, MDRin, MDRout, IRin;
    logic Gra, Grb, Rin, Rout, BAout, Yin, Cout, ADD, Zin, Zlowout;
    logic instr_done, halted, illegal;

    ldst_control_unit #(.OPW(5), .MEM_WAIT(W), .OP_LD(OP_LD), .OP_LDI(OP_LDI),
                        .OP_ST(OP_ST), .OP_HALT(OP_HALT)) dut (
        .clock(clock), .clear(clear), .run(run), .ir_opcode(ir_opcode),
        .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .memRead(memRead),
        .memWrite(memWrite), .ramEnable(ramEnable), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Grb(Grb), .Rin(Rin),
        .Rout(Rout), .BAout(BAout), .Yin(Yin), .Cout(Cout), .ADD(ADD),
        .Zin(Zin), .Zlowout(Zlowout), .instr_done(instr_done),
        .halted(halted), .illegal(illegal)
    );

    always #5 clock = ~clock;

    vec_t obs;
    assign obs = {illegal, halted, instr_done, Zlowout, Zin, ADD, Cout, Yin, BAout,
                  Rout, Rin, Grb, Gra, IRin, MDRout, MDRin, ramEnable, memWrite,
                  memRead, MARin, IncPC, PCout};

    int   compared   = 0;
    int   mismatched = 0;
    vec_t exp_q[$];

    task automatic check(input vec_t exp, input string tag);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input vec_t v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    // Reference: per-cycle strobe sets of one instruction, from F0 to its
    // final step (T3 for HALT/illegal), built from the step table.
    task automatic build(input logic [4:0] op);
        exp_q.delete();
        push(M_PCO | M_MARI | M_INC, 1);
        push(M_MRD | M_RAM | M_MDRI, W + 1);
        push(M_MDRO | M_IRI, 1);
        if (op == OP_LD || op == OP_LDI || op == OP_ST) begin
            push(M_GRB | M_BAO | M_YIN, 1);
            push(M_COUT | M_ADD | M_ZIN, 1);
            if (op == OP_LDI) begin
                push(M_ZLO | M_GRA | M_RIN | M_DONE, 1);
            end else if (op == OP_LD) begin
                push(M_ZLO | M_MARI, 1);
                push(M_MRD | M_RAM | M_MDRI, W + 1);
                push(M_MDRO | M_GRA | M_RIN | M_DONE, 1);
            end else begin
                push(M_ZLO | M_MARI, 1);
                push(M_GRA | M_ROUT | M_MDRI, 1);
                push(M_RAM | M_MWR, W);
                push(M_RAM | M_MWR | M_DONE, 1);
            end
        end else begin
            push('0, 1);
        end
    endtask

    // Entered at posedge+1 of the F0 cycle. drop_at<0 gives random run
    // in non-final steps; otherwise run=1 before step drop_at, 0 after.
    task automatic run_instr(input logic [4:0] op, input bit cont,
                             input int drop_at, input string tag);
        build(op);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == exp_q.size() - 1) run = cont;
            else if (drop_at >= 0)     run = (i < drop_at);
            else                       run = 1'($urandom_range(0, 1));
            ir_opcode = (i == W + 2 || i == W + 3) ? op : 5'($urandom);
            @(negedge clock);
            check(exp_q[i], $sformatf("%s_op%0h_step%0d", tag, op, i));
            @(posedge clock); #1;
        end
    endtask

    task automatic idle(input int k, input bit start);
        for (int i = 0; i < k; i++) begin
            run = 1'b0;
            ir_opcode = 5'($urandom);
            @(negedge clock);
            check('0, "idle_quiet");
            @(posedge clock); #1;
        end
        if (start) begin
            run = 1'b1;
            @(negedge clock);
            check('0, "idle_go");
            @(posedge clock); #1;
        end
    endtask

    initial begin
        clear = 1'b0; run = 1'b0; ir_opcode = '0;
        repeat (2) begin
            @(negedge clock);
            check('0, "reset_held");
        end
        @(posedge clock); #1;
        clear = 1'b1;
        idle(0, 1'b1);

        run_instr(OP_LD,  1'b1, -1, "ld");
        run_instr(OP_LDI, 1'b1, -1, "ldi");
        run_instr(OP_ST,  1'b1, -1, "st");
        run_instr(OP_LD,  1'b0, W + 4, "ld_drop");
        idle(3, 1'b1);

        for (int n = 0; n < 25; n++) begin
            logic [4:0] op;
            bit cont;
            case ($urandom_range(0, 2))
                0:       op = OP_LD;
                1:       op = OP_LDI;
                default: op = OP_ST;
            endcase
            cont = ($urandom_range(0, 3) != 0);
            run_instr(op, cont, -1, "rnd");
            if (!cont) idle($urandom_range(0, 3), 1'b1);
        end

        // Undefined opcode parks in HALTED with illegal set.
        run_instr(5'b10101, 1'b1, -1, "illegal");
        repeat (20) begin
            run = 1'b1;
            ir_opcode = 5'($urandom);
            @(negedge clock);
            check(M_HLT | M_ILL, "halted_illegal");
            @(posedge clock); #1;
        end
        clear = 1'b0; #1;
        check('0, "clear_from_halt_async");
        @(posedge clock); #1;
        clear = 1'b1;
        idle(1, 1'b1);

        // HALT parks without illegal.
        run_instr(OP_HALT, 1'b1, -1, "halt");
        repeat (3) begin
            @(negedge clock);
            check(M_HLT, "halted_only");
            @(posedge clock); #1;
        end
        clear = 1'b0; #1;
        check('0, "clear_from_halt2_async");
        @(posedge clock); #1;
        clear = 1'b1;
        idle(0, 1'b1);

        // Asynchronous clear in the middle of the fetch memory read.
        run = 1'b1;
        @(negedge clock);
        check(M_PCO | M_MARI | M_INC, "f0_before_clear");
        @(posedge clock); #1;
        @(negedge clock);
        check(M_MRD | M_RAM | M_MDRI, "f1_before_clear");
        #1 clear = 1'b0;
        #1 check('0, "clear_mid_f1_async");
        @(posedge clock); #1;
        @(negedge clock);
        check('0, "clear_held");
        @(posedge clock); #1;
        clear = 1'b1;
        idle(0, 1'b1);
        run_instr(OP_LD, 1'b0, -1, "ld_restart");
        idle(2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
